// File: rtl/cdc_tx_arbiter.sv
// cdc_tx_arbiter: write-side scheduler for the 8-bit GMII-bound CDC FIFO.
// Two frame sources share the single FIFO write port. Port 1 carries time-sync
// frames and port 0 carries normal traffic. The scheduler keeps frames contiguous,
// inserts a fixed idle gap after each frame so the read side sees rdempty between
// frames, truncates frames longer than MAX_LEN and aborts a frame on FIFO overflow.
// Ports:
//   i_wr_clk, i_wr_rst_n             write clock, async active-low reset
//   i_pN_req / o_pN_gnt              per-port frame request (level) and grant
//   iv_pN_data / i_pN_data_wr        per-port byte and byte valid
//   i_fifo_overflow_pulse            1-cycle overflow strobe from the FIFO
//   ov_data / o_data_wr              byte and write enable to the FIFO
//   o_len_err_pulse                  1-cycle pulse, frame exceeded MAX_LEN
//   ov_p0/p1_frame_cnt, ov_overflow_cnt  wrapping 16-bit statistics
module cdc_tx_arbiter #(
    parameter int unsigned IFG_CYCLES  = 16,
    parameter int unsigned MAX_LEN     = 1522,
    parameter int unsigned GNT_TIMEOUT = 64,
    parameter int unsigned STRICT_PRIO = 1
) (
    input  logic        i_wr_clk,
    input  logic        i_wr_rst_n,
    input  logic        i_p0_req,
    output logic        o_p0_gnt,
    input  logic [7:0]  iv_p0_data,
    input  logic        i_p0_data_wr,
    input  logic        i_p1_req,
    output logic        o_p1_gnt,
    input  logic [7:0]  iv_p1_data,
    input  logic        i_p1_data_wr,
    input  logic        i_fifo_overflow_pulse,
    output logic [7:0]  ov_data,
    output logic        o_data_wr,
    output logic        o_len_err_pulse,
    output logic [15:0] ov_p0_frame_cnt,
    output logic [15:0] ov_p1_frame_cnt,
    output logic [15:0] ov_overflow_cnt
);

    localparam int unsigned LEN_W = 11;
    localparam int unsigned CNT_W = 16;
    localparam int unsigned GAP_W = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;
    localparam int unsigned TMO_W = (GNT_TIMEOUT > 1) ? $clog2(GNT_TIMEOUT) : 1;

    typedef enum logic [1:0] {
        IDLE_S  = 2'd0,
        GRANT_S = 2'd1,
        TRANS_S = 2'd2,
        GAP_S   = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic               sel_q, sel_d;           // 1 = port 1 owns the write port
    logic               rr_last_q, rr_last_d;   // last granted port
    logic               p0_gnt_q, p0_gnt_d;
    logic               p1_gnt_q, p1_gnt_d;
    logic [7:0]         data_q, data_d;
    logic               data_wr_q, data_wr_d;
    logic               len_err_q, len_err_d;
    logic               len_err_seen_q, len_err_seen_d;
    logic               discard_q, discard_d;
    logic [LEN_W-1:0]   byte_cnt_q, byte_cnt_d;
    logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
    logic [TMO_W-1:0]   tmo_cnt_q, tmo_cnt_d;
    logic [CNT_W-1:0]   p0_cnt_q, p0_cnt_d;
    logic [CNT_W-1:0]   p1_cnt_q, p1_cnt_d;
    logic [CNT_W-1:0]   ovf_cnt_q, ovf_cnt_d;

    logic               pick_c;
    logic               sel_wr_c;
    logic [7:0]         sel_data_c;

    // Arbitration winner when idle; reset value of rr_last_q makes port 1 win first.
    assign pick_c     = (i_p0_req && i_p1_req) ? ((STRICT_PRIO != 0) ? 1'b1 : ~rr_last_q)
                                               : i_p1_req;
    assign sel_wr_c   = sel_q ? i_p1_data_wr : i_p0_data_wr;
    assign sel_data_c = sel_q ? iv_p1_data   : iv_p0_data;

    // State and datapath registers.
    always_ff @(posedge i_wr_clk or negedge i_wr_rst_n) begin
        if (!i_wr_rst_n) begin
            state_q        <= IDLE_S;
            sel_q          <= 1'b0;
            rr_last_q      <= 1'b0;
            p0_gnt_q       <= 1'b0;
            p1_gnt_q       <= 1'b0;
            data_q         <= '0;
            data_wr_q      <= 1'b0;
            len_err_q      <= 1'b0;
            len_err_seen_q <= 1'b0;
            discard_q      <= 1'b0;
            byte_cnt_q     <= '0;
            gap_cnt_q      <= '0;
            tmo_cnt_q      <= '0;
            p0_cnt_q       <= '0;
            p1_cnt_q       <= '0;
            ovf_cnt_q      <= '0;
        end else begin
            state_q        <= state_d;
            sel_q          <= sel_d;
            rr_last_q      <= rr_last_d;
            p0_gnt_q       <= p0_gnt_d;
            p1_gnt_q       <= p1_gnt_d;
            data_q         <= data_d;
            data_wr_q      <= data_wr_d;
            len_err_q      <= len_err_d;
            len_err_seen_q <= len_err_seen_d;
            discard_q      <= discard_d;
            byte_cnt_q     <= byte_cnt_d;
            gap_cnt_q      <= gap_cnt_d;
            tmo_cnt_q      <= tmo_cnt_d;
            p0_cnt_q       <= p0_cnt_d;
            p1_cnt_q       <= p1_cnt_d;
            ovf_cnt_q      <= ovf_cnt_d;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d        = state_q;
        sel_d          = sel_q;
        rr_last_d      = rr_last_q;
        p0_gnt_d       = p0_gnt_q;
        p1_gnt_d       = p1_gnt_q;
        data_d         = data_q;
        data_wr_d      = 1'b0;
        len_err_d      = 1'b0;
        len_err_seen_d = len_err_seen_q;
        discard_d      = discard_q;
        byte_cnt_d     = byte_cnt_q;
        gap_cnt_d      = gap_cnt_q;
        tmo_cnt_d      = tmo_cnt_q;
        p0_cnt_d       = p0_cnt_q;
        p1_cnt_d       = p1_cnt_q;
        ovf_cnt_d      = i_fifo_overflow_pulse ? (ovf_cnt_q + CNT_W'(1)) : ovf_cnt_q;

        unique case (state_q)
            IDLE_S: begin
                discard_d      = 1'b0;
                len_err_seen_d = 1'b0;
                if (i_p0_req || i_p1_req) begin
                    sel_d     = pick_c;
                    rr_last_d = pick_c;
                    p1_gnt_d  = pick_c;
                    p0_gnt_d  = ~pick_c;
                    tmo_cnt_d = '0;
                    state_d   = GRANT_S;
                end
            end
            GRANT_S: begin
                if (sel_wr_c) begin
                    data_d     = sel_data_c;
                    data_wr_d  = 1'b1;
                    byte_cnt_d = LEN_W'(1);
                    state_d    = TRANS_S;
                end else if (tmo_cnt_q == TMO_W'(GNT_TIMEOUT - 1)) begin
                    // Source never started: withdraw the grant, no gap needed.
                    p0_gnt_d = 1'b0;
                    p1_gnt_d = 1'b0;
                    state_d  = IDLE_S;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
                end
            end
            TRANS_S: begin
                if (i_fifo_overflow_pulse) begin
                    discard_d = 1'b1;
                end
                if (sel_wr_c) begin
                    if (byte_cnt_q < LEN_W'(MAX_LEN)) begin
                        byte_cnt_d = byte_cnt_q + LEN_W'(1);
                        if (!discard_q) begin
                            data_d    = sel_data_c;
                            data_wr_d = 1'b1;
                        end
                    end else if (!len_err_seen_q) begin
                        len_err_d      = 1'b1;
                        len_err_seen_d = 1'b1;
                    end
                end else begin
                    // Frame end; an overflow in this same cycle still aborts it.
                    p0_gnt_d  = 1'b0;
                    p1_gnt_d  = 1'b0;
                    gap_cnt_d = '0;
                    state_d   = GAP_S;
                    if (!discard_q && !i_fifo_overflow_pulse) begin
                        if (sel_q) p1_cnt_d = p1_cnt_q + CNT_W'(1);
                        else       p0_cnt_d = p0_cnt_q + CNT_W'(1);
                    end
                end
            end
            GAP_S: begin
                if (gap_cnt_q == GAP_W'(IFG_CYCLES - 1)) begin
                    state_d = IDLE_S;
                end else begin
                    gap_cnt_d = gap_cnt_q + GAP_W'(1);
                end
            end
            default: state_d = IDLE_S;
        endcase
    end

    assign o_p0_gnt        = p0_gnt_q;
    assign o_p1_gnt        = p1_gnt_q;
    assign ov_data         = data_q;
    assign o_data_wr       = data_wr_q;
    assign o_len_err_pulse = len_err_q;
    assign ov_p0_frame_cnt = p0_cnt_q;
    assign ov_p1_frame_cnt = p1_cnt_q;
    assign ov_overflow_cnt = ovf_cnt_q;

endmodule

// File: tb/tb_cdc_tx_arbiter.sv
// Self-checking bench for cdc_tx_arbiter: scoreboard of expected FIFO bytes plus
// per-scenario tasks. A second instance with STRICT_PRIO=0 checks round-robin order.
module tb_cdc_tx_arbiter;

    localparam int unsigned MAX_LEN = 1522;
    localparam int unsigned IFG     = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        p0_req = 1'b0, p1_req = 1'b0;
    logic        p0_wr = 1'b0, p1_wr = 1'b0;
    logic [7:0]  p0_data = '0, p1_data = '0;
    logic        ovf = 1'b0;

    logic        p0_gnt, p1_gnt, o_wr, o_lerr;
    logic [7:0]  o_data;
    logic [15:0] p0_cnt, p1_cnt, ovf_cnt;

    logic        rr_p0_gnt, rr_p1_gnt, rr_wr, rr_lerr;
    logic [7:0]  rr_data;
    logic [15:0] rr_p0_cnt, rr_p1_cnt, rr_ovf_cnt;

    int          n_vec = 0;
    int          n_err = 0;
    int          wr_cycles = 0;
    int          lerr_cnt = 0;
    logic [7:0]  sb[$];

    always #5 clk = ~clk;

    cdc_tx_arbiter u_dut (
        .i_wr_clk(clk), .i_wr_rst_n(rst_n),
        .i_p0_req(p0_req), .o_p0_gnt(p0_gnt), .iv_p0_data(p0_data), .i_p0_data_wr(p0_wr),
        .i_p1_req(p1_req), .o_p1_gnt(p1_gnt), .iv_p1_data(p1_data), .i_p1_data_wr(p1_wr),
        .i_fifo_overflow_pulse(ovf), .ov_data(o_data), .o_data_wr(o_wr),
        .o_len_err_pulse(o_lerr), .ov_p0_frame_cnt(p0_cnt), .ov_p1_frame_cnt(p1_cnt),
        .ov_overflow_cnt(ovf_cnt)
    );

    cdc_tx_arbiter #(.STRICT_PRIO(0)) u_rr (
        .i_wr_clk(clk), .i_wr_rst_n(rst_n),
        .i_p0_req(p0_req), .o_p0_gnt(rr_p0_gnt), .iv_p0_data(p0_data), .i_p0_data_wr(p0_wr),
        .i_p1_req(p1_req), .o_p1_gnt(rr_p1_gnt), .iv_p1_data(p1_data), .i_p1_data_wr(p1_wr),
        .i_fifo_overflow_pulse(ovf), .ov_data(rr_data), .o_data_wr(rr_wr),
        .o_len_err_pulse(rr_lerr), .ov_p0_frame_cnt(rr_p0_cnt), .ov_p1_frame_cnt(rr_p1_cnt),
        .ov_overflow_cnt(rr_ovf_cnt)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        p0_req = 1'b0; p1_req = 1'b0; p0_wr = 1'b0; p1_wr = 1'b0; ovf = 1'b0;
        sb.delete();
        repeat (3) cyc();
        rst_n = 1'b1;
        cyc();
        wr_cycles = 0;
        lerr_cnt  = 0;
    endtask

    // Step until a grant appears on the chosen instance; port = -1 if the budget expires.
    task automatic wait_gnt(input bit use_rr, input int budget, output int waited, output int port);
        port = -1;
        waited = 0;
        while (waited < budget && port < 0) begin
            cyc();
            waited++;
            if (use_rr ? rr_p1_gnt : p1_gnt)      port = 1;
            else if (use_rr ? rr_p0_gnt : p0_gnt) port = 0;
        end
    endtask

    // Stream n bytes on a port then one data_wr=0 cycle; the non-selected port carries junk.
    // Expected bytes: the first MAX_LEN, and nothing after the byte that carried overflow.
    task automatic send_frame(input int port, input int n, input int base, input int ovf_idx);
        logic [7:0] b;
        for (int k = 1; k <= n; k++) begin
            b = 8'(base + k - 1);
            if (port == 1) begin
                p1_data = b; p1_wr = 1'b1;
                p0_data = 8'($urandom); p0_wr = 1'($urandom_range(0, 1));
            end else begin
                p0_data = b; p0_wr = 1'b1;
                p1_data = 8'($urandom); p1_wr = 1'($urandom_range(0, 1));
            end
            ovf = (k == ovf_idx);
            if (k <= int'(MAX_LEN) && (ovf_idx == 0 || k <= ovf_idx)) sb.push_back(b);
            cyc();
        end
        p0_wr = 1'b0; p1_wr = 1'b0; ovf = 1'b0;
        cyc();
    endtask

    task automatic test_reset();
        apply_reset();
        n_vec++;
        if ({p0_gnt, p1_gnt, o_wr, o_lerr} !== 4'b0 || o_data !== 8'h00) begin
            n_err++;
            $display("FAIL reset_outputs: gnt0=%b gnt1=%b wr=%b lerr=%b data=%h, want all 0",
                     p0_gnt, p1_gnt, o_wr, o_lerr, o_data);
        end
        n_vec++;
        if (p0_cnt !== 16'd0 || p1_cnt !== 16'd0 || ovf_cnt !== 16'd0) begin
            n_err++;
            $display("FAIL reset_counters: p0=%0d p1=%0d ovf=%0d, want 0", p0_cnt, p1_cnt, ovf_cnt);
        end
    endtask

    task automatic test_p0_frame();
        int w, p;
        apply_reset();
        p0_req = 1'b1;
        wait_gnt(1'b0, 8, w, p);
        n_vec++;
        if (p !== 0 || w !== 1) begin
            n_err++;
            $display("FAIL p0_grant: port=%0d latency=%0d, want port 0 latency 1", p, w);
        end
        p0_req = 1'b0;
        send_frame(0, 64, 0, 0);
        n_vec++;
        if (p0_gnt !== 1'b0 || p0_cnt !== 16'd1) begin
            n_err++;
            $display("FAIL p0_frame_end: gnt=%b cnt=%0d, want gnt 0 cnt 1", p0_gnt, p0_cnt);
        end
        n_vec++;
        if (wr_cycles !== 64 || sb.size() !== 0) begin
            n_err++;
            $display("FAIL p0_frame_len: wr_cycles=%0d left=%0d, want 64 and 0", wr_cycles, sb.size());
        end
        // Gap cycles, one IDLE sampling cycle, then the registered grant.
        p0_req = 1'b1;
        wait_gnt(1'b0, 40, w, p);
        n_vec++;
        if (p !== 0 || w !== int'(IFG) + 1) begin
            n_err++;
            $display("FAIL p0_gap: port=%0d wait=%0d, want port 0 wait %0d", p, w, IFG + 1);
        end
        p0_req = 1'b0;
    endtask

    task automatic test_strict_prio();
        int w, p;
        apply_reset();
        p0_req = 1'b1; p1_req = 1'b1;
        wait_gnt(1'b0, 8, w, p);
        n_vec++;
        if (p !== 1 || p0_gnt !== 1'b0) begin
            n_err++;
            $display("FAIL prio_first: port=%0d gnt0=%b, want port 1 only", p, p0_gnt);
        end
        send_frame(1, 8, 8'h80, 0);
        p1_req = 1'b0;
        wait_gnt(1'b0, 40, w, p);
        n_vec++;
        if (p !== 0 || w !== int'(IFG) + 1) begin
            n_err++;
            $display("FAIL prio_p0_after_gap: port=%0d wait=%0d, want port 0 wait %0d", p, w, IFG + 1);
        end
        p1_req = 1'b1;
        send_frame(0, 8, 8'h40, 0);
        wait_gnt(1'b0, 40, w, p);
        n_vec++;
        if (p !== 1 || p0_gnt !== 1'b0) begin
            n_err++;
            $display("FAIL prio_p1_again: port=%0d gnt0=%b, want port 1", p, p0_gnt);
        end
        n_vec++;
        if (p0_cnt !== 16'd1 || p1_cnt !== 16'd1 || wr_cycles !== 16 || sb.size() !== 0) begin
            n_err++;
            $display("FAIL prio_counts: p0=%0d p1=%0d wr=%0d left=%0d, want 1 1 16 0",
                     p0_cnt, p1_cnt, wr_cycles, sb.size());
        end
        p0_req = 1'b0; p1_req = 1'b0;
    endtask

    // Grants that time out return to IDLE without a gap, so the RR order shows directly.
    task automatic test_round_robin();
        int w, p, hi;
        int exp_seq[3] = '{1, 0, 1};
        apply_reset();
        p0_req = 1'b1; p1_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wait_gnt(1'b1, 8, w, p);
            n_vec++;
            if (p !== exp_seq[i]) begin
                n_err++;
                $display("FAIL rr_order[%0d]: port=%0d, want %0d", i, p, exp_seq[i]);
            end
            hi = 0;
            while ((rr_p0_gnt || rr_p1_gnt) && hi < 100) begin
                hi++;
                cyc();
            end
        end
        p0_req = 1'b0; p1_req = 1'b0;
    endtask

    task automatic test_max_len();
        int w, p;
        apply_reset();
        p1_req = 1'b1;
        wait_gnt(1'b0, 8, w, p);
        p1_req = 1'b0;
        send_frame(1, 1530, 8'h10, 0);
        n_vec++;
        if (wr_cycles !== int'(MAX_LEN) || sb.size() !== 0) begin
            n_err++;
            $display("FAIL maxlen_bytes: wr_cycles=%0d left=%0d, want %0d and 0", wr_cycles, sb.size(), MAX_LEN);
        end
        n_vec++;
        if (lerr_cnt !== 1 || p1_cnt !== 16'd1) begin
            n_err++;
            $display("FAIL maxlen_err: pulses=%0d p1_cnt=%0d, want 1 and 1", lerr_cnt, p1_cnt);
        end
    endtask

    task automatic test_overflow();
        int w, p;
        apply_reset();
        p0_req = 1'b1;
        wait_gnt(1'b0, 8, w, p);
        p0_req = 1'b0;
        send_frame(0, 100, 0, 20);
        n_vec++;
        if (wr_cycles !== 20 || sb.size() !== 0) begin
            n_err++;
            $display("FAIL ovf_bytes: wr_cycles=%0d left=%0d, want 20 and 0", wr_cycles, sb.size());
        end
        n_vec++;
        if (ovf_cnt !== 16'd1 || p0_cnt !== 16'd0) begin
            n_err++;
            $display("FAIL ovf_counts: ovf=%0d p0=%0d, want 1 and 0", ovf_cnt, p0_cnt);
        end
        p0_req = 1'b1;
        wait_gnt(1'b0, 40, w, p);
        n_vec++;
        if (p !== 0 || w !== int'(IFG) + 1) begin
            n_err++;
            $display("FAIL ovf_gap: port=%0d wait=%0d, want port 0 wait %0d", p, w, IFG + 1);
        end
        p0_req = 1'b0;
    endtask

    task automatic test_timeout();
        int w, p, hi;
        apply_reset();
        p0_req = 1'b1;
        wait_gnt(1'b0, 8, w, p);
        p0_req = 1'b0;
        p1_req = 1'b1;
        hi = 0;
        while (p0_gnt && hi < 200) begin
            hi++;
            cyc();
        end
        n_vec++;
        if (p !== 0 || hi !== 64) begin
            n_err++;
            $display("FAIL timeout_len: port=%0d gnt_cycles=%0d, want port 0 for 64", p, hi);
        end
        cyc();
        n_vec++;
        if (p1_gnt !== 1'b1 || wr_cycles !== 0 || p0_cnt !== 16'd0) begin
            n_err++;
            $display("FAIL timeout_next: gnt1=%b wr=%0d p0_cnt=%0d, want 1 0 0", p1_gnt, wr_cycles, p0_cnt);
        end
        p1_req = 1'b0;
    endtask

    task automatic test_reset_mid_frame();
        int w, p;
        apply_reset();
        p0_req = 1'b1;
        wait_gnt(1'b0, 8, w, p);
        p0_req = 1'b0;
        send_frame(0, 12, 8'hA0, 0);
        p0_req = 1'b1;
        wait_gnt(1'b0, 40, w, p);
        p0_req = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            p0_data = 8'(8'h50 + k); p0_wr = 1'b1;
            if (k <= 9) sb.push_back(8'(8'h50 + k));
            cyc();
        end
        rst_n = 1'b0;
        #1;
        n_vec++;
        if ({p0_gnt, p1_gnt, o_wr} !== 3'b0 || o_data !== 8'h00 || p0_cnt !== 16'd0) begin
            n_err++;
            $display("FAIL async_reset: gnt0=%b gnt1=%b wr=%b data=%h p0_cnt=%0d, want 0",
                     p0_gnt, p1_gnt, o_wr, o_data, p0_cnt);
        end
        n_vec++;
        if (sb.size() !== 0 || wr_cycles !== 21) begin
            n_err++;
            $display("FAIL reset_drop: left=%0d wr=%0d, want 0 and 21", sb.size(), wr_cycles);
        end
        p0_wr = 1'b0;
        apply_reset();
        p0_req = 1'b1;
        wait_gnt(1'b0, 8, w, p);
        p0_req = 1'b0;
        send_frame(0, 16, 8'hC0, 0);
        n_vec++;
        if (p0_cnt !== 16'd1 || wr_cycles !== 16 || sb.size() !== 0) begin
            n_err++;
            $display("FAIL post_reset_frame: p0_cnt=%0d wr=%0d left=%0d, want 1 16 0",
                     p0_cnt, wr_cycles, sb.size());
        end
    endtask

    initial begin
        fork
            // Scoreboard: every FIFO write must match the next expected byte.
            forever begin
                @(negedge clk);
                if (o_wr === 1'b1) begin
                    logic [7:0] exp_b;
                    wr_cycles++;
                    n_vec++;
                    if (sb.size() == 0) begin
                        n_err++;
                        $display("FAIL sb_unexpected: data=%h written, no byte expected", o_data);
                    end else begin
                        exp_b = sb.pop_front();
                        if (o_data !== exp_b) begin
                            n_err++;
                            $display("FAIL sb_data: got %h, want %h", o_data, exp_b);
                        end
                    end
                end
                if (o_lerr === 1'b1) lerr_cnt++;
            end
            begin
                #500us;
                $display("FAIL watchdog: simulation time limit reached");
                $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
                $fatal(1, "watchdog");
            end
        join_none
        test_reset();
        test_p0_frame();
        test_strict_prio();
        test_round_robin();
        test_max_len();
        test_overflow();
        test_timeout();
        test_reset_mid_frame();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
